// File: rtl/pipeline_stall_controller.sv
// Stall/flush arbiter for the 5-stage pipeline.
// Sequences multi-cycle EX ops and tracks stall statistics.
module pipeline_stall_controller #(
  parameter int EX_CYCLES      = 4,
  parameter int WATCHDOG_LIMIT = 1024,
  parameter int PERF_WIDTH     = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_stall_request,
  input  logic                  ex_stall_request,
  input  logic                  ex_multi_start,
  input  logic                  flush_request,
  input  logic [31:0]           flush_target,
  output logic [5:0]            stall,
  output logic                  flush,
  output logic [31:0]           new_program_counter,
  output logic                  ex_multi_busy,
  output logic [PERF_WIDTH-1:0] stall_cycles,
  output logic                  stall_timeout
);

  localparam int RW = $clog2(WATCHDOG_LIMIT + 1);
  localparam logic [7:0] CNT_INIT = 8'(EX_CYCLES - 2);
  localparam logic [RW-1:0] WD_LIM = RW'(WATCHDOG_LIMIT);

  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_ID   = 6'b000111;
  localparam logic [5:0] ST_EX   = 6'b001111;

  typedef enum logic {IDLE, MULTI} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;
  logic [RW-1:0]         run_q, run_d;
  logic                  to_q, to_d;
  logic                  stalled;

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: flush aborts, MULTI counts down, start enters MULTI.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_request) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == MULTI) begin
      if (cnt_q == 8'd0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end else if (ex_multi_start) begin
      state_d = MULTI;
      cnt_d   = CNT_INIT;
    end
  end

  // Outputs: priority arbitration, forced idle while reset is held.
  always_comb begin
    stall               = ST_NONE;
    flush               = 1'b0;
    new_program_counter = 32'h0;
    ex_multi_busy       = 1'b0;
    if (reset) begin
      ex_multi_busy = (state_q == MULTI) ||
                      (!flush_request && ex_multi_start);
      if (flush_request) begin
        flush               = 1'b1;
        new_program_counter = flush_target;
      end else if (state_q == MULTI || ex_stall_request ||
                   ex_multi_start) begin
        stall = ST_EX;
      end else if (id_stall_request) begin
        stall = ST_ID;
      end
    end
  end

  assign stalled = (stall != ST_NONE);

  // Performance counter and watchdog next values.
  always_comb begin
    perf_d = perf_q + PERF_WIDTH'(stalled);
    run_d  = '0;
    to_d   = to_q;
    if (stalled) begin
      run_d = (run_q >= WD_LIM) ? WD_LIM : run_q + RW'(1);
    end
    if (run_d == WD_LIM) begin
      to_d = 1'b1;
    end
  end

  // Performance and watchdog registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_q <= '0;
      run_q  <= '0;
      to_q   <= 1'b0;
    end else begin
      perf_q <= perf_d;
      run_q  <= run_d;
      to_q   <= to_d;
    end
  end

  assign stall_cycles  = perf_q;
  assign stall_timeout = to_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller.
// Driver queues expectations, negedge monitor checks.
module tb_pipeline_stall_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_r, ex_r, ms, fl;
  logic [31:0] tgt;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] npc;
  logic        busy;
  logic [31:0] cycles;
  logic        tout;

  pipeline_stall_controller #(
    .EX_CYCLES(4),
    .WATCHDOG_LIMIT(8),
    .PERF_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .id_stall_request(id_r),
    .ex_stall_request(ex_r),
    .ex_multi_start(ms),
    .flush_request(fl),
    .flush_target(tgt),
    .stall(stall),
    .flush(flush),
    .new_program_counter(npc),
    .ex_multi_busy(busy),
    .stall_cycles(cycles),
    .stall_timeout(tout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  st;
    logic        fl;
    logic [31:0] pc;
    logic        busy;
    logic [31:0] cyc;
    logic        to;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc_m = 0;

  task automatic chk(input string nm, input string f,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%h want=%h", nm, f, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT outputs are valid mid-period.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "stall", 32'(stall), 32'(e.st));
      chk(e.nm, "flush", 32'(flush), 32'(e.fl));
      chk(e.nm, "npc", npc, e.pc);
      chk(e.nm, "busy", 32'(busy), 32'(e.busy));
      chk(e.nm, "cycles", cycles, e.cyc);
      chk(e.nm, "timeout", 32'(tout), 32'(e.to));
    end
  end

  // Drive one cycle of inputs and queue what the outputs must be.
  task automatic step(input logic rst, input logic id, input logic ex,
                      input logic m, input logic f, input logic [31:0] t,
                      input logic [5:0] es, input logic ef,
                      input logic [31:0] ep, input logic eb,
                      input logic eto, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; id_r = id; ex_r = ex; ms = m; fl = f; tgt = t;
    if (!rst) cyc_m = 0;
    e.st = es; e.fl = ef; e.pc = ep; e.busy = eb;
    e.cyc = cyc_m; e.to = eto; e.nm = nm;
    q.push_back(e);
    if (es != 6'd0) cyc_m = cyc_m + 1;
  endtask

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [31:0] VEC = 32'hBFC00380;

  initial begin
    reset = 1'b0;
    id_r = 1'b1; ex_r = 1'b1; ms = 1'b1; fl = 1'b1; tgt = 32'hFFFF_FFFF;
    step(0, 1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 0, 0, 0, "rst_a");
    step(0, 1, 1, 1, 1, 32'hFFFF_FFFF, S0, 0, 0, 0, 0, "rst_b");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "rel");
    step(1, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, "lu");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "lu_after");
    step(1, 1, 0, 1, 0, 0, SE, 0, 0, 1, 0, "mc_t0");
    step(1, 1, 0, 0, 0, 0, SE, 0, 0, 1, 0, "mc_t1");
    step(1, 1, 0, 1, 0, 0, SE, 0, 0, 1, 0, "mc_t2");
    step(1, 1, 0, 0, 0, 0, SE, 0, 0, 1, 0, "mc_t3");
    step(1, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, "mc_t4");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "mc_t5");
    step(1, 0, 0, 1, 0, 0, SE, 0, 0, 1, 0, "fm_t0");
    step(1, 0, 0, 1, 1, VEC, S0, 1, VEC, 1, 0, "fm_t1");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "fm_t2");
    step(1, 1, 1, 0, 1, 32'h1234_5678, S0, 1, 32'h1234_5678, 0, 0,
         "fl_prio");
    step(1, 0, 0, 1, 1, 32'h0000_0040, S0, 1, 32'h0000_0040, 0, 0,
         "fl_start");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "fl_after");
    step(1, 1, 1, 0, 0, 0, SE, 0, 0, 0, 0, "ex_wins");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "ex_after");
    for (int i = 0; i < 7; i++)
      step(1, 0, 1, 0, 0, 0, SE, 0, 0, 0, 0, "wd_run7a");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_gap");
    for (int i = 0; i < 7; i++)
      step(1, 0, 1, 0, 0, 0, SE, 0, 0, 0, 0, "wd_run7b");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "wd_gap2");
    for (int i = 0; i < 8; i++)
      step(1, 0, 1, 0, 0, 0, SE, 0, 0, 0, 0, "wd_run8");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 1, "wd_set");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 1, "wd_sticky");
    step(1, 0, 0, 1, 0, 0, SE, 0, 0, 1, 1, "ar_t0");
    step(0, 1, 1, 1, 0, 0, S0, 0, 0, 0, 0, "ar_hold");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "ar_rel");
    step(1, 0, 0, 0, 0, 0, S0, 0, 0, 0, 0, "ar_idle");
    step(1, 1, 0, 0, 0, 0, SI, 0, 0, 0, 0, "ar_lu");
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
